sr_flop_sync: RTL and testbench



---
 rtl/sr_flop_sync_if.sv | 20 ++
 rtl/sr_flop_sync.sv | 102 ++++++++++
 tb/tb_sr_flop_sync.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sr_flop_sync_if.sv
// Bundles the per-bit set/reset requests and the registered state outputs of sr_flop_sync.
// The err_count signal exists only when SR_FLOP_ERRCNT_EN is defined.
interface sr_flop_sync_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] invalid;
`ifdef SR_FLOP_ERRCNT_EN
  logic [7:0]       err_count;

  modport master (output s, r, input q, qn, invalid, err_count);
  modport slave  (input s, r, output q, qn, invalid, err_count);
`else
  modport master (output s, r, input q, qn, invalid);
  modport slave  (input s, r, output q, qn, invalid);
`endif
endinterface

// File: rtl/sr_flop_sync.sv
// WIDTH-bit clocked SR storage element with a compile-time S=R=1 policy and a registered invalid flag.
// Optional saturating S=R=1 event counter is enabled by defining SR_FLOP_ERRCNT_EN.
module sr_flop_sync #(
  parameter int WIDTH        = 1,
  parameter int INVALID_MODE = 0,
  parameter int RESET_Q      = 0
) (
  input  logic            clk,
  input  logic            reset,
  sr_flop_sync_if.slave   bus
);

  // Any mode outside 0..3 falls back to hold.
  localparam int ModeEff = (INVALID_MODE >= 0 && INVALID_MODE <= 3) ? INVALID_MODE : 1;
  localparam logic ResetBit = (RESET_Q != 0);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qn_q, qn_d;
  logic [WIDTH-1:0] invalid_q, invalid_d;

  always_comb begin
    q_d       = q_q;
    qn_d      = qn_q;
    invalid_d = bus.s & bus.r;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({bus.s[i], bus.r[i]})
        2'b00: begin
          q_d[i]  = q_q[i];
          qn_d[i] = qn_q[i];
        end
        2'b10: begin
          q_d[i]  = 1'b1;
          qn_d[i] = 1'b0;
        end
        2'b01: begin
          q_d[i]  = 1'b0;
          qn_d[i] = 1'b1;
        end
        default: begin
          case (ModeEff)
            0: begin
              q_d[i]  = 1'b0;
              qn_d[i] = 1'b0;
            end
            2: begin
              q_d[i]  = 1'b1;
              qn_d[i] = 1'b0;
            end
            3: begin
              q_d[i]  = 1'b0;
              qn_d[i] = 1'b1;
            end
            default: begin
              q_d[i]  = q_q[i];
              qn_d[i] = qn_q[i];
            end
          endcase
        end
      endcase
    end
  end

  // qn is its own register so the NOR-latch emulation can hold q=qn=0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q       <= {WIDTH{ResetBit}};
      qn_q      <= {WIDTH{~ResetBit}};
      invalid_q <= '0;
    end else begin
      q_q       <= q_d;
      qn_q      <= qn_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.qn      = qn_q;
  assign bus.invalid = invalid_q;

`ifdef SR_FLOP_ERRCNT_EN
  logic [7:0] errCount_q, errCount_d;

  // At most one count per edge no matter how many bits collide.
  always_comb begin
    errCount_d = errCount_q;
    if ((|(bus.s & bus.r)) && (errCount_q != 8'hFF)) begin
      errCount_d = errCount_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      errCount_q <= '0;
    end else begin
      errCount_q <= errCount_d;
    end
  end

  assign bus.err_count = errCount_q;
`endif

endmodule

// File: tb/tb_sr_flop_sync.sv
// Self-checking bench for sr_flop_sync: five instances (modes 0..3, plus RESET_Q=1) driven in parallel
// and compared against a rule-level reference model after every clock edge.
module tb_sr_flop_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sDrv, rDrv;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  sr_flop_sync_if #(.WIDTH(4)) bus0 ();
  sr_flop_sync_if #(.WIDTH(4)) bus1 ();
  sr_flop_sync_if #(.WIDTH(4)) bus2 ();
  sr_flop_sync_if #(.WIDTH(4)) bus3 ();
  sr_flop_sync_if #(.WIDTH(4)) bus4 ();

  assign bus0.s = sDrv;  assign bus0.r = rDrv;
  assign bus1.s = sDrv;  assign bus1.r = rDrv;
  assign bus2.s = sDrv;  assign bus2.r = rDrv;
  assign bus3.s = sDrv;  assign bus3.r = rDrv;
  assign bus4.s = sDrv;  assign bus4.r = rDrv;

  sr_flop_sync #(.WIDTH(4), .INVALID_MODE(0), .RESET_Q(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  sr_flop_sync #(.WIDTH(4), .INVALID_MODE(1), .RESET_Q(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  sr_flop_sync #(.WIDTH(4), .INVALID_MODE(2), .RESET_Q(0)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
  sr_flop_sync #(.WIDTH(4), .INVALID_MODE(3), .RESET_Q(0)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));
  sr_flop_sync #(.WIDTH(4), .INVALID_MODE(1), .RESET_Q(1)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  logic [3:0] obsQ[5], obsQn[5], obsInv[5];
  assign obsQ[0] = bus0.q;  assign obsQn[0] = bus0.qn;  assign obsInv[0] = bus0.invalid;
  assign obsQ[1] = bus1.q;  assign obsQn[1] = bus1.qn;  assign obsInv[1] = bus1.invalid;
  assign obsQ[2] = bus2.q;  assign obsQn[2] = bus2.qn;  assign obsInv[2] = bus2.invalid;
  assign obsQ[3] = bus3.q;  assign obsQn[3] = bus3.qn;  assign obsInv[3] = bus3.invalid;
  assign obsQ[4] = bus4.q;  assign obsQn[4] = bus4.qn;  assign obsInv[4] = bus4.invalid;

`ifdef SR_FLOP_ERRCNT_EN
  logic [7:0] obsErr[5];
  assign obsErr[0] = bus0.err_count;
  assign obsErr[1] = bus1.err_count;
  assign obsErr[2] = bus2.err_count;
  assign obsErr[3] = bus3.err_count;
  assign obsErr[4] = bus4.err_count;
`endif

  // Reference model state, one entry per instance.
  logic [3:0] mQ[5], mQn[5], mInv[5];
  int         mErr;

  function automatic int modeOf(int k);
    return (k == 4) ? 1 : k;
  endfunction

  function automatic logic resetValOf(int k);
    return (k == 4);
  endfunction

  // Returns {q, qn} for one bit from the truth table and the instance's S=R=1 policy.
  function automatic logic [1:0] bitNext(int mode, logic qOld, logic qnOld, logic s, logic r);
    if (!s && !r) return {qOld, qnOld};
    if (s && !r)  return 2'b10;
    if (!s && r)  return 2'b01;
    case (mode)
      0:       return 2'b00;
      2:       return 2'b10;
      3:       return 2'b01;
      default: return {qOld, qnOld};
    endcase
  endfunction

  task automatic modelUpdate(logic rst, logic [3:0] s, logic [3:0] r);
    logic [1:0] nb;
    for (int k = 0; k < 5; k++) begin
      if (!rst) begin
        mQ[k]   = {4{resetValOf(k)}};
        mQn[k]  = ~{4{resetValOf(k)}};
        mInv[k] = 4'b0000;
      end else begin
        for (int b = 0; b < 4; b++) begin
          nb = bitNext(modeOf(k), mQ[k][b], mQn[k][b], s[b], r[b]);
          mQ[k][b]  = nb[1];
          mQn[k][b] = nb[0];
        end
        mInv[k] = s & r;
      end
    end
    if (!rst) mErr = 0;
    else if ((s & r) != 4'b0000 && mErr < 255) mErr = mErr + 1;
  endtask

  task automatic checkVal(string tag, int k, logic [7:0] obs, logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s inst%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 5; k++) begin
      checkVal("q", k, {4'b0, obsQ[k]}, {4'b0, mQ[k]});
      checkVal("qn", k, {4'b0, obsQn[k]}, {4'b0, mQn[k]});
      checkVal("invalid", k, {4'b0, obsInv[k]}, {4'b0, mInv[k]});
`ifdef SR_FLOP_ERRCNT_EN
      checkVal("err_count", k, obsErr[k], mErr[7:0]);
`endif
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
  task automatic applyStimulus(logic rst, logic [3:0] s, logic [3:0] r);
    @(negedge clk);
    reset = rst;
    sDrv  = s;
    rDrv  = r;
    @(posedge clk);
    modelUpdate(rst, s, r);
    #1;
    checkOutput();
  endtask

  initial begin
    reset = 1'b0;
    sDrv  = 4'b0000;
    rDrv  = 4'b0000;
    mErr  = 0;
    for (int k = 0; k < 5; k++) begin
      mQ[k] = 'x; mQn[k] = 'x; mInv[k] = 'x;
    end

    $display("[TB] reset with set requests present");
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    checkVal("rst_q_const", 0, {4'b0, obsQ[0]}, 8'h00);
    checkVal("rst_qn_const", 0, {4'b0, obsQn[0]}, 8'h0F);

    $display("[TB] S=R=1 from q=0 across all policies");
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    checkVal("m1_q_const", 1, {4'b0, obsQ[1]}, 8'h00);
    checkVal("m2_q_const", 2, {4'b0, obsQ[2]}, 8'h0F);
    checkVal("m3_qn_const", 3, {4'b0, obsQn[3]}, 8'h0F);

    $display("[TB] set / hold / reset / hold");
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 4'b1111);
    applyStimulus(1'b1, 4'b0000, 4'b0000);

    $display("[TB] mode 0 collapse then recovery");
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    checkVal("m0_qn_zero", 0, {4'b0, obsQn[0]}, 8'h00);
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 4'b1111, 4'b0000);

    $display("[TB] per-bit independence and mid-pattern reset");
    applyStimulus(1'b1, 4'b0000, 4'b1111);
    applyStimulus(1'b1, 4'b0101, 4'b0011);
    checkVal("indep_q_const", 0, {4'b0, obsQ[0]}, 8'h04);
    checkVal("indep_inv_const", 0, {4'b0, obsInv[0]}, 8'h01);
    applyStimulus(1'b0, 4'b0101, 4'b0011);

    $display("[TB] randomized sequence");
    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(0, 15) != 0), 4'($urandom), 4'($urandom));
    end

`ifdef SR_FLOP_ERRCNT_EN
    $display("[TB] error counter saturation");
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'b1, 4'b1111, 4'b1111);
    end
    checkVal("err_sat_const", 0, obsErr[0], 8'hFF);
    applyStimulus(1'b0, 4'b1111, 4'b1111);
    checkVal("err_clr_const", 0, obsErr[0], 8'h00);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
